signed_divider: RTL and testbench

- Sequential 8-bit signed restoring divider. It is the inverse-operation companion to the lab's shift-add multiplier and uses the same switch/button/LED/hex board interface.
- The dividend is loaded into B from the switches. The divisor is taken from the switches when Run is pressed.
- The quotient ends in B and the remainder ends in A. Both are shown on the hex displays.
- Sits at the same top level as the multiplier and is driven by the same board I/O wrapper.

---
 rtl/signed_divider.sv | 162 ++++++++++++++++
 tb/tb_signed_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// Sequential 8-bit signed restoring divider: dividend loaded into B, divisor taken at Run.
// Quotient (truncated toward zero) ends in B, remainder (dividend's sign) ends in A.
module signed_divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearA_LoadB,
    input  logic       Run,
    input  logic [7:0] S,
    output logic       X,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic [6:0] AhexL,
    output logic [6:0] AhexU,
    output logic [6:0] BhexL,
    output logic [6:0] BhexU
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [7:0]  d_r;
    logic        x_r;
    logic        sq_r;
    logic        sr_r;
    logic [2:0]  cnt_r;

    logic [7:0]  b_mag_s;
    logic [7:0]  s_mag_s;
    logic [9:0]  trial_s;
    logic [7:0]  shift_a_s;

    // Active-low 7-segment encoding for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Operand magnitudes and the restoring trial subtraction of the shifted remainder
    always_comb begin
        b_mag_s   = b_r[7] ? (8'd0 - b_r) : b_r;
        s_mag_s   = S[7] ? (8'd0 - S) : S;
        shift_a_s = {a_r[6:0], b_r[7]};
        trial_s   = {1'b0, a_r, b_r[7]} - {2'b00, d_r};
    end

    // Divider control and datapath
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            d_r     <= 8'h00;
            x_r     <= 1'b0;
            sq_r    <= 1'b0;
            sr_r    <= 1'b0;
            cnt_r   <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!ClearA_LoadB) begin
                        b_r <= S;
                        a_r <= 8'h00;
                        x_r <= 1'b0;
                    end else if (!Run) begin
                        state_r <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    d_r   <= s_mag_s;
                    sq_r  <= b_r[7] ^ S[7];
                    sr_r  <= b_r[7];
                    cnt_r <= 3'd0;
                    if (S == 8'h00) begin
                        x_r     <= 1'b1;
                        a_r     <= b_r;
                        b_r     <= 8'hFF;
                        state_r <= DONE;
                    end else if ((b_r == 8'h80) && (S == 8'hFF)) begin
                        x_r     <= 1'b1;
                        a_r     <= 8'h00;
                        b_r     <= 8'h80;
                        state_r <= DONE;
                    end else begin
                        x_r     <= 1'b0;
                        a_r     <= 8'h00;
                        b_r     <= b_mag_s;
                        state_r <= ITER;
                    end
                end
                ITER: begin
                    // The remainder never reaches |D| <= 128, so it fits in 8 bits after the step
                    if (!trial_s[9]) begin
                        a_r <= trial_s[7:0];
                        b_r <= {b_r[6:0], 1'b1};
                    end else begin
                        a_r <= shift_a_s;
                        b_r <= {b_r[6:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= ITER;
                    end
                end
                FIX: begin
                    b_r     <= sq_r ? (8'd0 - b_r) : b_r;
                    a_r     <= sr_r ? (8'd0 - a_r) : a_r;
                    state_r <= DONE;
                end
                DONE: begin
                    if (Run) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign X     = x_r;
    assign Aval  = a_r;
    assign Bval  = b_r;
    assign AhexL = hex7(a_r[3:0]);
    assign AhexU = hex7(a_r[7:4]);
    assign BhexL = hex7(b_r[3:0]);
    assign BhexU = hex7(b_r[7:4]);

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: expected {X,A,B} queued at Run, compared in DONE.
module tb_signed_divider;

    logic       Clk;
    logic       Reset;
    logic       ClearA_LoadB;
    logic       Run;
    logic [7:0] S;
    logic       X;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic [6:0] AhexL;
    logic [6:0] AhexU;
    logic [6:0] BhexL;
    logic [6:0] BhexU;

    int vec_cnt;
    int err_cnt;
    logic [16:0] sb_q[$];
    logic [6:0]  seg_tab[16];

    signed_divider dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ClearA_LoadB (ClearA_LoadB),
        .Run          (Run),
        .S            (S),
        .X            (X),
        .Aval         (Aval),
        .Bval         (Bval),
        .AhexL        (AhexL),
        .AhexU        (AhexU),
        .BhexL        (BhexL),
        .BhexU        (BhexU)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference result {X, A, B} from SV integer division (truncating, remainder takes dividend sign)
    function automatic logic [16:0] model(input logic [7:0] dv, input logic [7:0] ds);
        int n;
        int d;
        int q;
        int r;
        n = $signed(dv);
        d = $signed(ds);
        if (d == 0) return {1'b1, dv, 8'hFF};
        if (n == -128 && d == -1) return {1'b1, 8'h00, 8'h80};
        q = n / d;
        r = n % d;
        return {1'b0, r[7:0], q[7:0]};
    endfunction

    task automatic load(input logic [7:0] v);
        S = v;
        ClearA_LoadB = 1'b0;
        tick();
        ClearA_LoadB = 1'b1;
    endtask

    task automatic check_result(input string tag);
        logic [16:0] e;
        if (sb_q.size() == 0) begin
            check({tag, " sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " X"}, {15'd0, X}, {15'd0, e[16]});
            check({tag, " A"}, {8'd0, Aval}, {8'd0, e[15:8]});
            check({tag, " B"}, {8'd0, Bval}, {8'd0, e[7:0]});
            check({tag, " hexA"}, {2'd0, AhexU, AhexL}, {2'd0, seg_tab[e[15:12]], seg_tab[e[11:8]]});
            check({tag, " hexB"}, {2'd0, BhexU, BhexL}, {2'd0, seg_tab[e[7:4]], seg_tab[e[3:0]]});
        end
    endtask

    // Load, start and check one division after the given number of edges past the Run sample
    task automatic run_div(input string tag, input logic [7:0] dv, input logic [7:0] ds, input int lat);
        load(dv);
        S = ds;
        Run = 1'b0;
        sb_q.push_back(model(dv, ds));
        tick();
        repeat (lat) tick();
        check_result(tag);
        Run = 1'b1;
        tick();
    endtask

    initial begin
        logic [16:0] e;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vec_cnt = 0;
        err_cnt = 0;
        Reset = 1'b1;
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        S = 8'h00;
        tick();
        Reset = 1'b0;
        sb_q.push_back({1'b0, 8'h00, 8'h00});
        check_result("reset");

        // -59 / 7, then confirm DONE holds with Run still low
        load(8'hC5);
        S = 8'h07;
        Run = 1'b0;
        sb_q.push_back(model(8'hC5, 8'h07));
        sb_q.push_back(model(8'hC5, 8'h07));
        tick();
        repeat (11) tick();
        check_result("neg_pos");
        S = 8'h33;
        repeat (4) tick();
        check_result("neg_pos_hold");
        Run = 1'b1;
        tick();

        run_div("pos_neg", 8'h3B, 8'hF9, 11);
        run_div("pos_pos", 8'h64, 8'h07, 11);
        run_div("neg_neg", 8'h81, 8'hFD, 11);
        run_div("min_by_1", 8'h80, 8'h01, 11);
        run_div("small_big", 8'h03, 8'h80, 11);
        run_div("div_zero", 8'h05, 8'h00, 2);
        run_div("overflow", 8'h80, 8'hFF, 2);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] dv;
            logic [7:0] ds;
            dv = 8'($urandom_range(0, 255));
            ds = 8'($urandom_range(1, 255));
            run_div("random", dv, ds, 11);
        end

        // Reset in the middle of ITER; Run held low restarts on B=0
        load(8'h64);
        S = 8'h07;
        Run = 1'b0;
        tick();
        repeat (5) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sb_q.push_back({1'b0, 8'h00, 8'h00});
        check_result("mid_reset");
        sb_q.push_back(model(8'h00, 8'h07));
        tick();
        repeat (11) tick();
        check_result("zero_div");
        Run = 1'b1;
        tick();

        // Load and Run together: load wins, no division starts
        S = 8'hC5;
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        tick();
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        repeat (3) tick();
        sb_q.push_back({1'b0, 8'h00, 8'hC5});
        check_result("load_prio");

        // Load pulse and S change during ITER are ignored
        S = 8'h07;
        Run = 1'b0;
        sb_q.push_back(model(8'hC5, 8'h07));
        tick();
        repeat (4) tick();
        S = 8'h22;
        ClearA_LoadB = 1'b0;
        tick();
        ClearA_LoadB = 1'b1;
        repeat (6) tick();
        check_result("load_ignored");
        Run = 1'b1;
        tick();

        // Quotient left in B (-8) is the next dividend
        e = model(8'hF8, 8'h03);
        sb_q.push_back(e);
        S = 8'h03;
        Run = 1'b0;
        tick();
        repeat (11) tick();
        check_result("chained");
        Run = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
